// File: rtl/johnson_pkg.sv
// Shared Johnson-counter helpers: legality, phase decode, successor.
// Functions take a MAXW-wide vector plus the live width w.
package johnson_pkg;

  localparam int MAXW = 16;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  // Legal codes have at most one boundary between adjacent bits.
  function automatic logic jc_legal(
    input logic [MAXW-1:0] c,
    input int              w
  );
    int t;
    t = 0;
    for (int i = 0; i < MAXW - 1; i++)
      if (i < w - 1 && c[i] != c[i+1])
        t++;
    return t <= 1;
  endfunction

  function automatic int jc_phase(
    input logic [MAXW-1:0] c,
    input int              w
  );
    int ones;
    ones = 0;
    for (int i = 0; i < MAXW; i++)
      if (i < w)
        ones += int'(c[i]);
    if (c[w-1] || ones == 0)
      return ones;
    return 2 * w - ones;
  endfunction

  function automatic logic [MAXW-1:0] jc_next(
    input logic [MAXW-1:0] q,
    input int              w
  );
    logic [MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < MAXW - 1; i++)
      if (i < w - 1)
        r[i] = q[i+1];
    r[w-1] = ~q[0];
    return r;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decode: legality, phase index, one-hot.
// Shared by every consumer of the counter.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int W  = 4,
  parameter int PW = 3
) (
  input  logic [W-1:0]   code,
  output logic           legal,
  output logic [PW-1:0]  phase,
  output logic [2*W-1:0] onehot
);

  logic [MAXW-1:0] code_x;

  assign code_x = MAXW'(code);

  always_comb begin
    legal  = jc_legal(code_x, W);
    phase  = PW'(jc_phase(code_x, W));
    onehot = '0;
    if (legal)
      onehot[phase] = 1'b1;
  end

endmodule

// File: rtl/johnson_seq_monitor.sv
// Johnson counter monitor: lock FSM, sequence check, error count.
// All outputs are registered one cycle after the in_valid sample.
module johnson_seq_monitor
  import johnson_pkg::*;
#(
  parameter int W          = 4,
  parameter int PW         = 3,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int ECW        = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [W-1:0]   jc_in,
  input  logic           clr_err,
  output logic           out_valid,
  output logic [PW-1:0]  phase,
  output logic [2*W-1:0] phase_onehot,
  output logic           locked,
  output logic           illegal,
  output logic           seq_err,
  output logic           wrap_pulse,
  output logic [ECW-1:0] err_count
);

  localparam int CW = 4;

  mon_state_e      state, state_d;
  logic [W-1:0]    prev;
  logic [CW-1:0]   good_cnt, good_d;
  logic [CW-1:0]   bad_cnt, bad_d;
  logic            legal;
  logic [PW-1:0]   dec_phase;
  logic [2*W-1:0]  dec_oh;
  logic [MAXW-1:0] exp_x;
  logic            match;
  logic            seq_err_d;
  logic            wrap_d;
  logic [ECW-1:0]  err_d;

  johnson_decode #(
    .W  (W),
    .PW (PW)
  ) u_dec (
    .code   (jc_in),
    .legal  (legal),
    .phase  (dec_phase),
    .onehot (dec_oh)
  );

  assign exp_x  = jc_next(MAXW'(prev), W);
  assign match  = (exp_x == MAXW'(jc_in));
  assign locked = (state == LOCKED);

  always_comb begin
    state_d   = state;
    good_d    = good_cnt;
    bad_d     = bad_cnt;
    seq_err_d = 1'b0;
    wrap_d    = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (legal) begin
            state_d = CONFIRM;
            good_d  = '0;
          end
        end
        CONFIRM: begin
          if (!legal) begin
            state_d = HUNT;
          end else if (match) begin
            good_d = good_cnt + 1'b1;
            if (good_d == CW'(LOCK_CNT)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            bad_d  = '0;
            // only the last phase has phase 0 as its successor
            wrap_d = (dec_phase == '0);
          end else begin
            seq_err_d = 1'b1;
            bad_d     = bad_cnt + 1'b1;
            if (bad_d == CW'(UNLOCK_CNT))
              state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    err_d = err_count;
    if (clr_err)
      err_d = ECW'(seq_err_d);
    else if (seq_err_d && err_count != '1)
      err_d = err_count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      prev         <= '0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      out_valid    <= 1'b0;
      phase        <= '0;
      phase_onehot <= '0;
      illegal      <= 1'b0;
      seq_err      <= 1'b0;
      wrap_pulse   <= 1'b0;
      err_count    <= '0;
    end else begin
      state      <= state_d;
      good_cnt   <= good_d;
      bad_cnt    <= bad_d;
      err_count  <= err_d;
      out_valid  <= in_valid;
      illegal    <= in_valid & ~legal;
      seq_err    <= seq_err_d;
      wrap_pulse <= wrap_d;
      if (in_valid) begin
        prev <= jc_in;
        if (legal) begin
          phase        <= dec_phase;
          phase_onehot <= dec_oh;
        end else begin
          phase_onehot <= '0;
        end
      end
    end
  end

endmodule

// File: doc/johnson_seq_monitor.md
Name: johnson_seq_monitor

Overview:
- Downstream consumer of the 4-bit Johnson counter: samples its code, decodes it to a binary phase index and a one-hot phase vector, and checks both code legality and sequence order.
- Lock FSM qualifies the counter as healthy before downstream phase logic uses it.
- Reports illegal codes and sequence errors with a saturating error counter, plus a once-per-revolution wrap pulse.

Parameters:
- W, 4, Johnson register width; 2*W legal states.
- PW, 3, phase index width, equal to clog2(2*W).
- LOCK_CNT, 3, consecutive correct transitions needed to lock (1..15).
- UNLOCK_CNT, 2, consecutive bad samples in LOCKED that drop lock (1..15).
- ECW, 8, error counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  jc_in is sampled this cycle
- jc_in  in  W  Johnson code from counter; shift-right form, next = {~q[0], q[W-1:1]}
- clr_err  in  1  synchronous clear of err_count
- out_valid  out  1  registered copy of in_valid
- phase  out  PW  decoded phase index of last legal sample
- phase_onehot  out  2*W  one-hot of phase; all-zero when the sample was illegal
- locked  out  1  FSM is in LOCKED
- illegal  out  1  one-cycle pulse: sampled code is not a legal Johnson state
- seq_err  out  1  one-cycle pulse: a LOCKED sample is not the expected successor
- wrap_pulse  out  1  one-cycle pulse: LOCKED transition from phase 2W-1 to phase 0
- err_count  out  ECW  saturating count of seq_err events

Behaviour:
- Reset (rst_n low, async): every output is 0; FSM goes to HUNT; prev code and good/bad counters are 0. Release is synchronous to the next clk edge.
- All outputs are registered with 1-cycle latency from the in_valid sample. When in_valid = 0, state holds and all pulses are 0.
- Legality: code is legal iff it is of the form 1^k 0^(W-k) or 0^k 1^(W-k).
  - Phase map for W=4: 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7.
  - The same rule generalises to any W.
  - On an illegal sample, phase holds its last value and phase_onehot = 0.
- Expected successor: exp = {~prev[0], prev[W-1:1]}. prev updates on every valid sample, legal or not.
- FSM:
  - HUNT: a legal sample goes to CONFIRM with good_cnt = 0. An illegal sample stays in HUNT.
  - CONFIRM: a sample equal to exp increments good_cnt; at good_cnt = LOCK_CNT go to LOCKED.
    - A legal sample that is not exp sets good_cnt = 0 and stays in CONFIRM.
    - An illegal sample goes to HUNT.
  - LOCKED: a sample equal to exp sets bad_cnt = 0.
    - Any other sample (illegal, skipped, repeated) pulses seq_err, increments err_count and increments bad_cnt.
    - At bad_cnt = UNLOCK_CNT go to HUNT; locked deasserts on the same output edge.
- The illegal pulse fires in any state. seq_err fires only in LOCKED.
- wrap_pulse fires only in LOCKED, only on a correct transition from phase 2W-1 to phase 0.
- err_count saturates at 2^ECW-1. If clr_err and a seq_err occur in the same cycle, err_count = 1. clr_err alone gives 0.
- A repeated identical code (counter stalled while in_valid = 1) is an error; upstream must gate in_valid.

Decomposition:
- Shared package johnson_pkg holds:
  - the legality function
  - the code→phase function
  - the next-state function
  - FSM state encoding (HUNT = 2'd0, CONFIRM = 2'd1, LOCKED = 2'd2)
- One sub-module, johnson_decode: purely combinational legal/phase/onehot decode. It is reused by other consumers of the counter.
- FSM, counters and output registers live in johnson_seq_monitor.

Test Plan:
- Reset check: drive jc_in = 1100 with in_valid = 1 while rst_n is low. All outputs must stay 0, and must reassert 0 asynchronously when rst_n drops mid-cycle.
- Lock acquire: drive the legal sequence from 0000 with LOCK_CNT = 3. locked must rise on the output edge after the 4th sample (1110), with phase = 3 and phase_onehot = 8'b0000_1000.
- Wrap: continue the locked sequence through 0001→0000. wrap_pulse must be high exactly one cycle, with phase = 0, once per 8 samples, and err_count must stay 0.
- Illegal in LOCKED: inject 0101. illegal and seq_err must each pulse once, phase_onehot = 0, phase holds, err_count = 1, locked stays 1. Resume at {~0101[0], 0101[3:1]} = 0010? No: resume with the correct successor of the prior legal code, which counts as a second error, so bad_cnt = 2 drops lock. Check locked = 0 and err_count = 2.
- Stall and recovery: hold jc_in = 1110 for 2 valid cycles in LOCKED. This must give 1 seq_err. A correct sample afterwards resets bad_cnt, and lock is kept.
- Saturation and clear: with ECW = 2, force 5 errors (relocking between them). err_count must stay at 3. Asserting clr_err together with a new error must give err_count = 1.
